// File: rtl/computer_system_timer_scheduler.sv
// Round-robin scheduler that serves one requester at a time by programming an
// interval timer, waiting for its interrupt, and pulsing done for that channel.
module computer_system_timer_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_period,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic [2:0]           tmr_address,
  output logic                 tmr_chipselect,
  output logic                 tmr_write_n,
  output logic [15:0]          tmr_writedata,
  input  logic                 tmr_irq
);

  typedef enum logic [3:0] {
    StIdle, StArb, StWrPl, StWrPh, StWrClr, StWrCtl, StWait, StAck, StWrDis, StFin
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [31:0]     period_q, period_d;
  logic            abort_q, abort_d;

  logic            arb_found;
  logic [IDW-1:0]  arb_sel;
  logic [IDW-1:0]  arb_cand;
  logic [31:0]     arb_period;

  // Search starts one past the previous grant so every channel gets a turn.
  always_comb begin
    arb_found  = 1'b0;
    arb_sel    = '0;
    arb_cand   = '0;
    arb_period = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      arb_cand = IDW'((32'(last_q) + k) % NREQ);
      if (!arb_found && req[arb_cand]) begin
        arb_found = 1'b1;
        arb_sel   = arb_cand;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == arb_sel) arb_period = req_period[32*i +: 32];
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    period_d = period_q;
    abort_d  = abort_q;
    unique case (state_q)
      StIdle:  if (|req) state_d = StArb;
      StArb: begin
        if (!arb_found) begin
          state_d = StIdle;
        end else begin
          grant_d  = arb_sel;
          period_d = arb_period;
          // Periods below 2 cannot be timed, so the channel completes at once.
          state_d  = (arb_period < 32'd2) ? StFin : StWrPl;
        end
      end
      StWrPl:  state_d = StWrPh;
      StWrPh:  state_d = StWrClr;
      StWrClr: state_d = StWrCtl;
      StWrCtl: state_d = StWait;
      StWait: begin
        if (!req[grant_q]) begin
          abort_d = 1'b1;
          state_d = StAck;
        end else if (tmr_irq) begin
          state_d = StAck;
        end
      end
      StAck:   state_d = StWrDis;
      StWrDis: state_d = StFin;
      StFin: begin
        abort_d = 1'b0;
        last_d  = grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      last_q   <= IDW'(NREQ - 1);
      period_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      period_q <= period_d;
      abort_q  <= abort_d;
    end
  end

  // Timer bus is decoded straight from state: one write per write state.
  always_comb begin
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = 3'd0;
    tmr_writedata  = 16'd0;
    unique case (state_q)
      StWrPl:  begin tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd2;
                     tmr_writedata = period_q[15:0]; end
      StWrPh:  begin tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd3;
                     tmr_writedata = period_q[31:16]; end
      StWrClr: begin tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd0; end
      StWrCtl: begin tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd1;
                     tmr_writedata = 16'd1; end
      StAck:   begin tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd0; end
      StWrDis: begin tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd1; end
      default: ;
    endcase
  end

  always_comb begin
    done = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      done[i] = (state_q == StFin) && !abort_q && (grant_q == IDW'(i));
    end
  end

  assign busy     = (state_q != StIdle);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_computer_system_timer_scheduler.sv
// Scoreboard bench: stimulus queues expected timer writes and done pulses,
// a negedge monitor pops and compares them as the scheduler produces them.
module tb_computer_system_timer_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [32*NREQ-1:0] req_period;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [IDW-1:0]    grant_id;
  logic [2:0]        tmr_address;
  logic              tmr_chipselect;
  logic              tmr_write_n;
  logic [15:0]       tmr_writedata;
  logic              tmr_irq;

  computer_system_timer_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .req_period     (req_period),
    .done           (done),
    .busy           (busy),
    .grant_id       (grant_id),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_irq        (tmr_irq)
  );

  typedef struct {
    bit          is_done;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [3:0]  done_v;
    logic [1:0]  ch;
    int          at;
    bit          chk_irq;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int irq_cyc  = -100;
  int tcnt     = 0;
  int irq_delay = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input int ch, input int a, input int d, input int at);
    exp_t e;
    e.is_done = 1'b0; e.addr = 3'(a); e.data = 16'(d); e.done_v = '0;
    e.ch = 2'(ch); e.at = at; e.chk_irq = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_done(input int ch, input int at, input bit chk_irq);
    exp_t e;
    e.is_done = 1'b1; e.addr = '0; e.data = '0; e.done_v = 4'(1 << ch);
    e.ch = 2'(ch); e.at = at; e.chk_irq = chk_irq;
    q.push_back(e);
  endtask

  // The four programming writes; first_at < 0 leaves their timing unchecked.
  task automatic push_setup(input int ch, input logic [31:0] p, input int first_at);
    push_wr(ch, 2, int'(p[15:0]),  (first_at < 0) ? -1 : first_at);
    push_wr(ch, 3, int'(p[31:16]), (first_at < 0) ? -1 : first_at + 1);
    push_wr(ch, 0, 0,              (first_at < 0) ? -1 : first_at + 2);
    push_wr(ch, 1, 1,              (first_at < 0) ? -1 : first_at + 3);
  endtask

  task automatic push_service(input int ch, input logic [31:0] p, input int first_at);
    push_setup(ch, p, first_at);
    push_wr(ch, 0, 0, -1);
    push_wr(ch, 1, 0, -1);
    push_done(ch, -1, 1'b1);
  endtask

  // One cycle of environment: timer model and requesters that drop on done.
  task automatic step();
    @(negedge clk);
    if (!reset_n) begin
      tcnt = 0;
      tmr_irq = 1'b0;
    end else if (tmr_chipselect && !tmr_write_n) begin
      if (tmr_address == 3'd0) tmr_irq = 1'b0;
      if (tmr_address == 3'd1 && tmr_writedata == 16'd1 && irq_delay != 0) tcnt = irq_delay;
    end else if (tcnt != 0) begin
      tcnt--;
      if (tcnt == 0) begin
        tmr_irq = 1'b1;
        irq_cyc = cyc;
      end
    end
    req = req & ~done;
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    step();
    while ((busy || req != '0) && n < 300) begin
      step();
      n++;
    end
    check(name, 64'({busy, req}), 64'd0);
  endtask

  task automatic set_period(input int ch, input logic [31:0] p);
    req_period[32*ch +: 32] = p;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (tmr_chipselect || !tmr_write_n) begin
        if (q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_write: got addr=%0d data=%h expected none",
                   tmr_address, tmr_writedata);
        end else begin
          e = q.pop_front();
          check("timer_write", 64'({1'b0, tmr_chipselect, tmr_write_n, tmr_address,
                                    tmr_writedata, grant_id}),
                64'({e.is_done, 1'b1, 1'b0, e.addr, e.data, e.ch}));
          if (e.at >= 0) check("write_cycle", 64'(cyc), 64'(e.at));
        end
      end else begin
        check("idle_bus", 64'({tmr_address, tmr_writedata}), 64'd0);
      end
      if (done != '0) begin
        if (q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_done: got %b expected none", done);
        end else begin
          e = q.pop_front();
          check("done_pulse", 64'({1'b1, done, grant_id}), 64'({e.is_done, e.done_v, e.ch}));
          if (e.is_done && e.at >= 0) check("done_cycle", 64'(cyc), 64'(e.at));
          if (e.is_done && e.chk_irq) check("done_after_irq", 64'(cyc), 64'(irq_cyc + 3));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    req = '0;
    req_period = '0;
    tmr_irq = 1'b0;
    reset_n = 1'b0;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_grant", 64'(grant_id), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_bus", 64'({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}),
          64'({1'b0, 1'b1, 3'd0, 16'd0}));
    @(negedge clk);
    reset_n = 1'b1;

    // All four held: served 0,1,2,3, then 1001 wraps to 0 before 3.
    irq_delay = 3;
    set_period(0, 32'h0000_0010);
    set_period(1, 32'h0002_0003);
    set_period(2, 32'h1234_abcd);
    set_period(3, 32'h0000_ffff);
    for (int ch = 0; ch < 4; ch++) begin
      push_service(ch, req_period[32*ch +: 32], -1);
    end
    step();
    req = 4'b1111;
    wait_quiet("rr_all_quiet");
    push_service(0, 32'h0000_0010, -1);
    push_service(3, 32'h0000_ffff, -1);
    req = 4'b1001;
    wait_quiet("rr_wrap_quiet");

    // Single channel with exact write timing.
    irq_delay = 1;
    set_period(0, 32'h0001_0005);
    push_service(0, 32'h0001_0005, cyc + 2);
    req = 4'b0001;
    wait_quiet("ch0_quiet");

    // Short period: done with no timer traffic.
    set_period(1, 32'h0000_0001);
    push_done(1, cyc + 2, 1'b0);
    req = 4'b0010;
    wait_quiet("short_quiet");

    // Withdrawal during WAIT: teardown writes, no done.
    irq_delay = 0;
    set_period(2, 32'h0000_0005);
    push_setup(2, 32'h0000_0005, -1);
    push_wr(2, 0, 0, -1);
    push_wr(2, 1, 0, -1);
    req = 4'b0100;
    repeat (8) step();
    req[2] = 1'b0;
    wait_quiet("abort_quiet");
    check("abort_busy", 64'(busy), 64'd0);

    // Period changed after grant: writes keep the latched value.
    irq_delay = 2;
    set_period(0, 32'h0000_0007);
    push_service(0, 32'h0000_0007, cyc + 2);
    req = 4'b0001;
    step();
    step();
    set_period(0, 32'hdead_beef);
    wait_quiet("latch_quiet");

    // Reset in WAIT: immediate reset outputs, then channel 3 alone is granted.
    irq_delay = 0;
    set_period(0, 32'h0002_0004);
    push_setup(0, 32'h0002_0004, -1);
    req = 4'b0001;
    repeat (8) step();
    reset_n = 1'b0;
    req = '0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_grant", 64'(grant_id), 64'd0);
    check("midrst_bus", 64'({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}),
          64'({1'b0, 1'b1, 3'd0, 16'd0}));
    step();
    reset_n = 1'b1;
    step();
    set_period(3, 32'h0000_0001);
    push_done(3, cyc + 2, 1'b0);
    req = 4'b1000;
    wait_quiet("post_reset_quiet");

    step();
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
